// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_arb_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_pending_fifo.sv
// In-order queue of multi-cycle results awaiting a writeback slot; also exports a
// one-hot-per-register mask of every destination still queued.
module wb_pending_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [AW-1:0]                push_wn,
    input  logic [DW-1:0]                push_wd,
    input  logic                         pop,
    output logic [AW-1:0]                head_wn,
    output logic [DW-1:0]                head_wd,
    output logic                         full,
    output logic                         empty,
    output logic [clog2(DEPTH+1)-1:0]    count,
    output logic [(2**AW)-1:0]           pending_mask
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [AW-1:0]    wn_q [DEPTH];
    logic [AW-1:0]    wn_d [DEPTH];
    logic [DW-1:0]    wd_q [DEPTH];
    logic [DW-1:0]    wd_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_wn = wn_q[rd_ptr_q];
    assign head_wd = wd_q[rd_ptr_q];

    always_comb begin
        wn_d     = wn_q;
        wd_d     = wd_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            wn_d[wr_ptr_q]  = push_wn;
            wd_d[wr_ptr_q]  = push_wd;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        // Push only lands when not full and pop only when not empty, so the two
        // pointers never name the same slot in a cycle where both act.
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = next_ptr(rd_ptr_q);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) pending_mask[wn_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        wn_q <= wn_d;
        wd_q <= wd_d;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and queued
// multi-cycle results, forcing a one-cycle stall when the queue head waits too long.
// Optional macro WB_BYPASS_EN: idle-slot MC results are written the same cycle instead of queued.
module regfile_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8,
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pipe_we,
    input  logic [AW-1:0]                pipe_wn,
    input  logic [DW-1:0]                pipe_wd,
    input  logic                         mc_valid,
    output logic                         mc_ready,
    input  logic [AW-1:0]                mc_wn,
    input  logic [DW-1:0]                mc_wd,
    output logic                         stall_pipe,
    output logic                         rf_we,
    output logic [AW-1:0]                rf_wn,
    output logic [DW-1:0]                rf_wd,
    output logic [(2**AW)-1:0]           pending_mask,
    output logic [clog2(DEPTH+1)-1:0]    fifo_count
);

    localparam int WW = clog2(MAX_WAIT + 1);

    arb_state_e    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          pipe_req;
    logic          push, pop, bypass;
    logic          full, empty;
    logic [AW-1:0] head_wn;
    logic [DW-1:0] head_wd;

    wb_pending_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_wn      (mc_wn),
        .push_wd      (mc_wd),
        .pop          (pop),
        .head_wn      (head_wn),
        .head_wd      (head_wd),
        .full         (full),
        .empty        (empty),
        .count        (fifo_count),
        .pending_mask (pending_mask)
    );

    assign stall_pipe = (state_q == FORCE);

    always_comb begin
        state_d  = state_q;
        rf_we    = 1'b0;
        rf_wn    = '0;
        rf_wd    = '0;
        pop      = 1'b0;
        bypass   = 1'b0;
        mc_ready = rst && !full;
        pipe_req = pipe_we && (pipe_wn != '0);

        // In FORCE the pipeline is frozen and re-presents its write next cycle.
        if (state_q == FORCE) begin
            if (!empty) begin
                rf_we = 1'b1;
                rf_wn = head_wn;
                rf_wd = head_wd;
                pop   = 1'b1;
            end
        end else if (pipe_req) begin
            rf_we = 1'b1;
            rf_wn = pipe_wn;
            rf_wd = pipe_wd;
        end else if (!empty) begin
            rf_we = 1'b1;
            rf_wn = head_wn;
            rf_wd = head_wd;
            pop   = 1'b1;
        end else begin
`ifdef WB_BYPASS_EN
            if (mc_valid && (mc_wn != '0)) begin
                bypass = 1'b1;
                rf_we  = 1'b1;
                rf_wn  = mc_wn;
                rf_wd  = mc_wd;
            end
`endif
        end

        if (!rst) begin
            rf_we  = 1'b0;
            pop    = 1'b0;
            bypass = 1'b0;
        end

        // r0 results complete the handshake but are never stored.
        push = mc_valid && mc_ready && (mc_wn != '0) && !bypass;

        wait_d = (empty || pop) ? '0 : wait_q + WW'(1);

        if (state_q == FORCE) begin
            state_d = NORMAL;
        end else if (!empty && !pop && (wait_q == WW'(MAX_WAIT - 1))) begin
            state_d = FORCE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= NORMAL;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          pipe_we;
    logic [AW-1:0] pipe_wn;
    logic [DW-1:0] pipe_wd;
    logic          mc_valid;
    logic          mc_ready;
    logic [AW-1:0] mc_wn;
    logic [DW-1:0] mc_wd;
    logic          stall_pipe;
    logic          rf_we;
    logic [AW-1:0] rf_wn;
    logic [DW-1:0] rf_wd;
    logic [31:0]   pending_mask;
    logic [2:0]    fifo_count;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(
        .DEPTH    (4),
        .MAX_WAIT (8),
        .DW       (DW),
        .AW       (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_wn      (pipe_wn),
        .pipe_wd      (pipe_wd),
        .mc_valid     (mc_valid),
        .mc_ready     (mc_ready),
        .mc_wn        (mc_wn),
        .mc_wd        (mc_wd),
        .stall_pipe   (stall_pipe),
        .rf_we        (rf_we),
        .rf_wn        (rf_wn),
        .rf_wd        (rf_wd),
        .pending_mask (pending_mask),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        pipe_we  = 1'b1;
        pipe_wn  = 5'd5;
        pipe_wd  = 32'h0000_0bad;
        mc_valid = 1'b1;
        mc_wn    = 5'd3;
        mc_wd    = 32'h0000_0033;

        // 1: reset holds the MC port closed and the write port idle
        repeat (3) tick();
        #1;
        check("rst_mc_ready", mc_ready, 0);
        check("rst_rf_we", rf_we, 0);
        rst      = 1'b1;
        pipe_we  = 1'b0;
        mc_valid = 1'b0;
        #1;
        check("rel_count", fifo_count, 0);
        check("rel_stall", stall_pipe, 0);
        check("rel_mask", pending_mask, 0);
        check("rel_rf_we", rf_we, 0);

        // 2: idle drain of a single MC result
        mc_valid = 1'b1;
        mc_wn    = 5'd7;
        mc_wd    = 32'h0000_1234;
        #1;
        check("t2_ready", mc_ready, 1);
`ifdef WB_BYPASS_EN
        check("t2_byp_we", rf_we, 1);
        check("t2_byp_wn", rf_wn, 7);
        check("t2_byp_wd", rf_wd, 32'h1234);
        tick();
        mc_valid = 1'b0;
        #1;
        check("t2_byp_count", fifo_count, 0);
        check("t2_byp_mask", pending_mask, 0);
        check("t2_byp_we_after", rf_we, 0);
`else
        check("t2_we_same", rf_we, 0);
        tick();
        mc_valid = 1'b0;
        #1;
        check("t2_we", rf_we, 1);
        check("t2_wn", rf_wn, 7);
        check("t2_wd", rf_wd, 32'h1234);
        check("t2_mask_set", pending_mask, 32'h0000_0080);
        check("t2_count1", fifo_count, 1);
        tick();
        #1;
        check("t2_we_after", rf_we, 0);
        check("t2_count0", fifo_count, 0);
        check("t2_mask_clr", pending_mask, 0);
`endif

        // 3: pipeline owns every slot; the head is forced out on the 9th cycle
        pipe_we  = 1'b1;
        pipe_wn  = 5'd5;
        pipe_wd  = 32'h0000_aaaa;
        mc_valid = 1'b1;
        mc_wn    = 5'd9;
        mc_wd    = 32'h0000_0099;
        #1;
        check("t3_pipe_first", rf_wn, 5);
        tick();
        mc_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            check($sformatf("t3_stall_c%0d", k), stall_pipe, 0);
            check($sformatf("t3_wn_c%0d", k), rf_wn, 5);
            tick();
        end
        #1;
        check("t3_force_stall", stall_pipe, 1);
        check("t3_force_we", rf_we, 1);
        check("t3_force_wn", rf_wn, 9);
        check("t3_force_wd", rf_wd, 32'h99);
        tick();
        #1;
        check("t3_after_stall", stall_pipe, 0);
        check("t3_after_wn", rf_wn, 5);
        check("t3_after_wd", rf_wd, 32'haaaa);
        check("t3_after_count", fifo_count, 0);

        // 4: fill the queue behind a busy pipeline, then pop with a blocked push
        for (int i = 1; i <= 4; i++) begin
            mc_valid = 1'b1;
            mc_wn    = AW'(i);
            mc_wd    = 32'h100 + i;
            #1;
            check($sformatf("t4_ready_%0d", i), mc_ready, 1);
            tick();
        end
        mc_valid = 1'b0;
        #1;
        check("t4_full_count", fifo_count, 4);
        check("t4_full_ready", mc_ready, 0);
        check("t4_full_mask", pending_mask, 32'h0000_001e);
        pipe_we  = 1'b0;
        mc_valid = 1'b1;
        mc_wn    = 5'd6;
        mc_wd    = 32'h0000_0666;
        #1;
        check("t4_pop_ready", mc_ready, 0);
        check("t4_pop_we", rf_we, 1);
        check("t4_pop_wn", rf_wn, 1);
        check("t4_pop_wd", rf_wd, 32'h101);
        tick();
        mc_valid = 1'b0;
        #1;
        check("t4_count3", fifo_count, 3);
        check("t4_mask3", pending_mask, 32'h0000_001c);

        // 5: a pipeline write to r0 frees the slot for the queue
        pipe_we = 1'b1;
        pipe_wn = 5'd0;
        pipe_wd = 32'h0000_ffff;
        for (int i = 2; i <= 4; i++) begin
            #1;
            check($sformatf("t5_drain_we_%0d", i), rf_we, 1);
            check($sformatf("t5_drain_wn_%0d", i), rf_wn, AW'(i));
            tick();
        end
        #1;
        check("t5_empty_count", fifo_count, 0);
        check("t5_r0_we", rf_we, 0);
        pipe_we  = 1'b0;
        mc_valid = 1'b1;
        mc_wn    = 5'd0;
        mc_wd    = 32'h0000_5555;
        #1;
        check("t5_r0_ready", mc_ready, 1);
        check("t5_r0_same_we", rf_we, 0);
        tick();
        mc_valid = 1'b0;
        #1;
        check("t5_r0_count", fifo_count, 0);
        check("t5_r0_we_next", rf_we, 0);
        check("t5_r0_mask", pending_mask, 0);

        // 6: reset while three entries are draining
        pipe_we = 1'b1;
        pipe_wn = 5'd5;
        for (int i = 0; i < 3; i++) begin
            mc_valid = 1'b1;
            mc_wn    = AW'(10 + i);
            mc_wd    = 32'h200 + i;
            tick();
        end
        mc_valid = 1'b0;
        pipe_we  = 1'b0;
        #1;
        check("t6_count3", fifo_count, 3);
        check("t6_mask3", pending_mask, 32'h0000_1c00);
        check("t6_head_wn", rf_wn, 10);
        tick();
        #1;
        check("t6_count2", fifo_count, 2);
        rst = 1'b0;
        #1;
        check("t6_rst_we", rf_we, 0);
        check("t6_rst_ready", mc_ready, 0);
        tick();
        rst = 1'b1;
        #1;
        check("t6_post_count", fifo_count, 0);
        check("t6_post_mask", pending_mask, 0);
        check("t6_post_we", rf_we, 0);
        check("t6_post_stall", stall_pipe, 0);
        tick();
        #1;
        check("t6_post_we2", rf_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
